ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), over the same PS2_CLK/PS2_DAT pair that the receive controller listens on. It drives both lines open-drain using active-high pull-low enables and runs the full inhibit / request-to-send / bit-shift / ACK sequence. The top level arbitrates the shared pins and gates the receiver with tx_busy.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, command codes, timing helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INHIBIT    = 3'd1,
    RTS        = 3'd2,
    WAIT_FIRST = 3'd3,
    SHIFT      = 3'd4,
    FINISH     = 3'd5
  } ps2_state_t;

  // Commonly used host commands and the device acknowledge byte.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Width of the shared state timer; must hold the 15 ms start window at 50 MHz.
  localparam int TMR_W = 20;

  // Convert a duration in microseconds to system clock cycles.
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
// Handshake: a byte is transferred on a clock edge where tx_valid && tx_ready;
// tx_ready is high only while the transmitter is idle, and a request presented
// while busy is dropped, not queued. done pulses once per accepted byte, with
// nack/timeout describing the outcome in that same cycle.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       done;
  logic       nack;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, done, nack, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, done, nack, timeout
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, glitch filter that needs
// FILTER_CYC consecutive equal samples to change level, and a falling-edge
// strobe aligned with the filtered level change.
module ps2_line_sync #(
  parameter int FILTER_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYC + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Synchronize, then accept a new level only after a full run of equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      fall   <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_CYC - 1)) begin
        cnt_q <= '0;
        level <= sync_q[1];
        fall  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte
// with odd parity on device clock falling edges, then sample the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int INHIBIT_CYC  = us_to_cyc(CLK_HZ, 100),
  parameter int RTS_CYC      = us_to_cyc(CLK_HZ, 5),
  parameter int START_TO_CYC = us_to_cyc(CLK_HZ, 15_000),
  parameter int PKT_TO_CYC   = us_to_cyc(CLK_HZ, 2_000),
  parameter int FILTER_CYC   = 8
) (
  input  logic         CLOCK_50,
  input  logic         res,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe,
  output ps2_state_t   state_dbg
);

  localparam int HCW = $clog2(FILTER_CYC + 1);

  logic clk_lvl, clk_fall;
  logic dat_lvl, dat_fall_unused;

  ps2_line_sync #(.FILTER_CYC(FILTER_CYC)) u_clk_sync (
    .clk   (CLOCK_50),
    .rst   (res),
    .pin   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync #(.FILTER_CYC(FILTER_CYC)) u_dat_sync (
    .clk   (CLOCK_50),
    .rst   (res),
    .pin   (ps2_dat_in),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  ps2_state_t       state_q;
  logic [TMR_W-1:0] tmr_q;    // shared down-counter, reloaded on state entry
  logic [3:0]       edge_q;   // device falling edges seen so far
  logic [9:0]       sh_q;     // {stop, parity, data}; bit 0 goes out next
  logic [HCW-1:0]   hi_q;     // consecutive cycles both lines idle-high
  logic             clk_oe_q, dat_oe_q;
  logic             done_q, nack_q, timeout_q;

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.nack     = nack_q;
  assign bus.timeout  = timeout_q;
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_dat_oe   = dat_oe_q;
  assign state_dbg    = state_q;

  // Transaction sequencer with registered line enables and status.
  always_ff @(posedge CLOCK_50 or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      edge_q    <= '0;
      sh_q      <= '0;
      hi_q      <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;

      case (state_q)
        IDLE: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (bus.tx_valid) begin
            sh_q      <= {1'b1, ~^bus.tx_data, bus.tx_data};
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            edge_q    <= '0;
            clk_oe_q  <= 1'b1;
            tmr_q     <= TMR_W'(INHIBIT_CYC - 1);
            state_q   <= INHIBIT;
          end
        end

        // Clock held low long enough to abort any device frame.
        INHIBIT: begin
          if (tmr_q == '0) begin
            dat_oe_q <= 1'b1;
            tmr_q    <= TMR_W'(RTS_CYC - 1);
            state_q  <= RTS;
          end
        end

        // Data low (start bit) with clock still low, then release clock.
        RTS: begin
          if (tmr_q == '0) begin
            clk_oe_q <= 1'b0;
            tmr_q    <= TMR_W'(START_TO_CYC - 1);
            state_q  <= WAIT_FIRST;
          end
        end

        // First device falling edge: present data bit 0 and start packet timer.
        WAIT_FIRST: begin
          if (clk_fall) begin
            dat_oe_q <= ~sh_q[0];
            sh_q     <= {1'b1, sh_q[9:1]};
            edge_q   <= 4'd1;
            tmr_q    <= TMR_W'(PKT_TO_CYC - 1);
            state_q  <= SHIFT;
          end else if (tmr_q == '0) begin
            dat_oe_q  <= 1'b0;
            timeout_q <= 1'b1;
            hi_q      <= '0;
            tmr_q     <= TMR_W'(PKT_TO_CYC - 1);
            state_q   <= FINISH;
          end
        end

        // Edges 2..10 shift out data/parity/stop; edge 11 samples ACK and
        // takes priority over a packet timeout in the same cycle.
        SHIFT: begin
          if (clk_fall && edge_q == 4'd10) begin
            nack_q   <= dat_lvl;
            dat_oe_q <= 1'b0;
            hi_q     <= '0;
            tmr_q    <= TMR_W'(PKT_TO_CYC - 1);
            state_q  <= FINISH;
          end else if (tmr_q == '0) begin
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            timeout_q <= 1'b1;
            hi_q      <= '0;
            tmr_q     <= TMR_W'(PKT_TO_CYC - 1);
            state_q   <= FINISH;
          end else if (clk_fall) begin
            dat_oe_q <= ~sh_q[0];
            sh_q     <= {1'b1, sh_q[9:1]};
            edge_q   <= edge_q + 4'd1;
          end
        end

        // Lines released; wait for bus idle (or give up) before reporting.
        FINISH: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (clk_lvl && dat_lvl) hi_q <= hi_q + 1'b1;
          else                    hi_q <= '0;
          if ((clk_lvl && dat_lvl && hi_q == HCW'(FILTER_CYC - 1)) || tmr_q == '0) begin
            done_q  <= 1'b1;
            hi_q    <= '0;
            state_q <= IDLE;
          end
        end

        default: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host; a scoreboard checks each done against the frame the device saw.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 60;
  localparam int RTSC = 12;
  localparam int STO  = 3000;
  localparam int PTO  = 1200;
  localparam int FLT  = 4;
  localparam int HALF = 20;
  localparam int W    = 13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b1;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ps2_host_tx_if bus_if ();
  logic       ps2_clk_oe, ps2_dat_oe;
  ps2_state_t state_dbg;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0, glitch_low = 1'b0;
  logic       clk_pin, dat_pin;

  assign clk_pin = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign dat_pin = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_HZ(50_000_000), .INHIBIT_CYC(INH), .RTS_CYC(RTSC),
    .START_TO_CYC(STO), .PKT_TO_CYC(PTO), .FILTER_CYC(FLT)
  ) dut (
    .CLOCK_50   (clk),
    .res        (res),
    .bus        (bus_if),
    .ps2_clk_in (clk_pin),
    .ps2_dat_in (dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .state_dbg  (state_dbg)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  // Response word: {timeout, nack, start_ok, bits seen by device[9:0]}.
  function automatic logic [W-1:0] model(input logic [7:0] d, input int ack, input int nedges);
    int ones;
    logic [9:0] frame, seen;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    frame = {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    seen = '0;
    for (int i = 0; i < 10; i++) if (i < nedges) seen[i] = frame[i];
    return {(nedges < 11) ? 1'b1 : 1'b0, (nedges == 11 && ack == 0) ? 1'b1 : 1'b0, 1'b1, seen};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [9:0]   dev_bits = '0;
  logic         start_ok = 1'b0;
  int done_cnt = 0, done_cyc = 0, rel_cyc = 0, first_edge_cyc = 0;

  always @(negedge clk) begin
    logic [W-1:0] exp, got;
    if (bus_if.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done at cycle %0d (no transaction pending)", cyc);
      end else begin
        exp = exp_q.pop_front();
        got = {bus_if.timeout, bus_if.nack, start_ok, dev_bits};
        if (got !== exp) begin
          fails++;
          $display("FAIL response: got to/nack/start/bits=%b required %b", got, exp);
        end
      end
      tests++;
      if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
        fails++;
        $display("FAIL released_at_done: clk_oe=%b dat_oe=%b required 0 0", ps2_clk_oe, ps2_dat_oe);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue a byte and follow the host through inhibit and request-to-send.
  task automatic send(input logic [7:0] d);
    int n_inh, n_rts, b;
    @(posedge clk); #1;
    check("ready_idle", 32'(bus_if.tx_ready), 32'd1);
    bus_if.tx_data  = d;
    bus_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.tx_valid = 1'b0;
    check("busy_after_accept", {bus_if.tx_busy, bus_if.tx_ready}, 32'b10);
    n_inh = 0; b = 0;
    while (ps2_clk_oe && !ps2_dat_oe && b < INH + 50) begin
      n_inh++; b++; @(posedge clk); #1;
    end
    check("inhibit_long_enough", 32'(n_inh >= INH), 32'd1);
    n_rts = 0; b = 0;
    while (ps2_clk_oe && ps2_dat_oe && b < RTSC + 50) begin
      n_rts++; b++; @(posedge clk); #1;
    end
    check("rts_long_enough", 32'(n_rts >= RTSC), 32'd1);
    check("clock_released_data_low", {ps2_clk_oe, ps2_dat_oe}, 32'b01);
    rel_cyc = cyc;
  endtask

  // Device: waits for request-to-send, then clocks nedges falling edges,
  // sampling data on each rising edge; ack=1 pulls data low for edge 11.
  task automatic device(input int ack, input int nedges);
    int b;
    dev_bits = '0;
    start_ok = 1'b0;
    b = 0;
    while (!(clk_pin == 1'b1 && dat_pin == 1'b0) && b < 1000) begin
      @(posedge clk); b++;
    end
    if (b >= 1000) begin
      tests++; fails++;
      $display("FAIL rts_seen: device never saw request-to-send");
      return;
    end
    start_ok = 1'b1;
    repeat (30) @(posedge clk);
    for (int k = 1; k <= nedges; k++) begin
      #1 dev_clk_low = 1'b1;
      if (k == 1) first_edge_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      if (k <= 10) dev_bits[k-1] = dat_pin;
      if (k == 10 && ack != 0) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (HALF) @(posedge clk);
    end
  endtask

  task automatic run_txn(input logic [7:0] d, input int ack, input int nedges, input bit glitch);
    int prev, b;
    prev = done_cnt;
    exp_q.push_back(model(d, ack, nedges));
    send(d);
    // A request while busy must be dropped.
    bus_if.tx_data  = 8'($urandom_range(0, 255));
    bus_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.tx_valid = 1'b0;
    device(ack, nedges);
    if (glitch) begin
      @(posedge clk); #1 glitch_low = 1'b1;
      repeat (2) @(posedge clk);
      #1 glitch_low = 1'b0;
      repeat (20) @(posedge clk);
      #1 check("glitch_no_edge", 32'(state_dbg), 32'(WAIT_FIRST));
    end
    b = 0;
    while (done_cnt == prev && b < STO + PTO + 3000) begin
      @(posedge clk); b++;
    end
    check("done_seen", 32'(done_cnt != prev), 32'd1);
    if (nedges == 0)
      check("start_timeout_time",
            32'(done_cyc - rel_cyc >= STO && done_cyc - rel_cyc <= STO + 3 * FLT + 12), 32'd1);
    if (nedges > 0 && nedges < 11)
      check("packet_timeout_time",
            32'(done_cyc - first_edge_cyc >= PTO && done_cyc - first_edge_cyc <= PTO + 4 * FLT + 14), 32'd1);
    repeat (5) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prev;
    bus_if.tx_data  = 8'h00;
    bus_if.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus_if.tx_ready), 32'd1);
    check("reset_busy_done", {bus_if.tx_busy, bus_if.done, bus_if.nack, bus_if.timeout}, 32'd0);
    check("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 32'd0);
    res = 1'b0;
    repeat (20) @(posedge clk);

    run_txn(CMD_SET_LEDS, 1, 11, 1'b0);   // ACK
    run_txn(8'hF4, 1, 11, 1'b0);          // ACK
    run_txn(8'($urandom_range(0, 255)), 0, 11, 1'b0); // no ACK
    run_txn(CMD_RESET, 1, 0, 1'b1);       // device never clocks, glitch ignored
    run_txn(CMD_ECHO, 1, 5, 1'b0);        // device stops after 5 edges
    for (int i = 0; i < 6; i++)
      run_txn(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 11, 1'b0);

    // Reset in the middle of shifting: lines released at once, no done.
    prev = done_cnt;
    send(8'hA5);
    fork
      device(1, 11);
      begin
        int b;
        b = 0;
        while (state_dbg != SHIFT && b < 2000) begin
          @(posedge clk); #1; b++;
        end
        check("reached_shift", 32'(state_dbg), 32'(SHIFT));
        repeat (60) @(posedge clk);
        #3 res = 1'b1;
        #1 check("reset_releases_lines", {ps2_clk_oe, ps2_dat_oe}, 32'd0);
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(bus_if.tx_ready), 32'd1);
      end
    join
    repeat (100) @(posedge clk);
    check("no_done_after_reset", 32'(done_cnt), 32'(prev));

    run_txn(8'($urandom_range(0, 255)), 1, 11, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
